// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master is the issuing pipeline stage; the slave is muldiv_unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_by_zero;
  logic            overflow_flag;
  logic            busy;

  modport master (
    output flush, in_valid, op, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, div_by_zero, overflow_flag, busy
  );

  modport slave (
    input  flush, in_valid, op, operand1, operand2, out_ready,
    output in_ready, out_valid, result, div_by_zero, overflow_flag, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a sign-fix cycle.
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN+1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  muldiv_unit_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_op;
  logic            r_neg;   // product / quotient needs negation
  logic            r_sa;    // dividend was negative (remainder sign)
  logic [XLEN-1:0] r_m;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] r_hi;    // product high half or partial remainder
  logic [XLEN-1:0] r_lo;    // multiplier/product low half or dividend/quotient
  logic [XLEN-1:0] r_result;
  logic            r_dz;
  logic            r_ovf;

  logic            w_sa, w_sb, w_na, w_nb, w_dz, w_ovf;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_fix;

  // Signedness: divides are signed when funct3[0]==0; MUL/MULH signed both,
  // MULHSU signed rs1 only, MULHU unsigned.
  always_comb begin
    w_sa    = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    w_sb    = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
    w_na    = w_sa & bus.operand1[XLEN-1];
    w_nb    = w_sb & bus.operand2[XLEN-1];
    w_a_mag = w_na ? (~bus.operand1 + 1'b1) : bus.operand1;
    w_b_mag = w_nb ? (~bus.operand2 + 1'b1) : bus.operand2;
    w_dz    = bus.op[2] & (bus.operand2 == '0);
    w_ovf   = bus.op[2] & ~bus.op[0] & (bus.operand1 == MIN_NEG) & (bus.operand2 == '1);
    if (w_dz) w_special = bus.op[1] ? bus.operand1 : '1;
    else      w_special = bus.op[1] ? '0 : MIN_NEG;
  end

  // One iteration: add-and-shift-right for multiply, shift-subtract for divide.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_m};
  end

  always_comb begin
    w_prod = {r_hi, r_lo};
    if (r_neg) w_prod = ~w_prod + 1'b1;
    w_quo  = r_neg ? (~r_lo + 1'b1) : r_lo;
    w_rem  = r_sa  ? (~r_hi + 1'b1) : r_hi;
    case (r_op)
      3'b000:                 w_fix = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix = w_quo;
      default:                w_fix = w_rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_sa     <= 1'b0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_op  <= bus.op;
          r_neg <= w_na ^ w_nb;
          r_sa  <= w_na;
          r_hi  <= '0;
          r_cnt <= '0;
          r_m   <= bus.op[2] ? w_b_mag : w_a_mag;
          r_lo  <= bus.op[2] ? w_a_mag : w_b_mag;
          r_dz  <= w_dz;
          r_ovf <= w_ovf & ~w_dz;
          if (w_dz || w_ovf) begin
            r_result <= w_special;
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!r_op[2]) begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
          end else if (!w_diff[XLEN]) begin
            r_hi <= w_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b1};
          end else begin
            r_hi <= w_shift[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], 1'b0};
          end
          if (r_cnt == CNT_W'(XLEN-1)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_result <= w_fix;
          r_state  <= S_DONE;
        end
        S_DONE: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == S_IDLE);
  assign bus.out_valid     = (r_state == S_DONE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.result        = r_result;
  assign bus.div_by_zero   = r_dz;
  assign bus.overflow_flag = r_ovf;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32) with hand-computed results.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_unit_if #(.XLEN(32)) bus();
  muldiv_unit #(.XLEN(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Issue one op at a negedge and wait for out_valid; lat counts posedges
  // after the accepting edge. The result is left pending (not consumed).
  task automatic issue_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat, output logic dz,
                            output logic ov, output logic saw_ready);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0; saw_ready = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = bus.result; dz = bus.div_by_zero; ov = bus.overflow_flag;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.overflow_flag} !== 5'b10000
        || bus.result !== 32'h0) begin
      failures++;
      $display("FAIL reset: rdy/vld/busy/dz/ov=%b result=%h, want 10000 00000000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.overflow_flag}, bus.result);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; logic dz, ov, sr;
    issue_wait(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, dz, ov, sr);
    checks++;
    if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result: got %h want ffffffeb", r); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++;
    if (sr !== 1'b0) begin failures++; $display("FAIL mul_in_ready_busy: in_ready seen high while busy"); end
    checks++;
    if ({dz, ov} !== 2'b00) begin failures++; $display("FAIL mul_flags: got %b want 00", {dz, ov}); end
    consume();
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat; logic dz, ov, sr;
    issue_wait(3'b001, 32'h80000000, 32'h80000000, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h40000000) begin failures++; $display("FAIL mulh: got %h want 40000000", r); end
    issue_wait(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu: got %h want fffffffe", r); end
    issue_wait(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu: got %h want ffffffff", r); end
    issue_wait(3'b000, 32'h00012345, 32'h00010000, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h23450000) begin failures++; $display("FAIL mul_lo: got %h want 23450000", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; logic dz, ov, sr;
    issue_wait(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div: got %h want fffffffd", r); end
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL div_latency: got %0d want 33", lat); end
    issue_wait(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem: got %h want ffffffff", r); end
    issue_wait(3'b101, 32'd100, 32'd7, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'd14) begin failures++; $display("FAIL divu: got %h want 0000000e", r); end
    issue_wait(3'b111, 32'd100, 32'd7, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'd2) begin failures++; $display("FAIL remu: got %h want 00000002", r); end
    issue_wait(3'b110, 32'd7, 32'hFFFFFFFE, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'd1) begin failures++; $display("FAIL rem_pos_dividend: got %h want 00000001", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat; logic dz, ov, sr;
    issue_wait(3'b101, 32'd5, 32'd0, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFFF || {dz, ov} !== 2'b10 || lat !== 0) begin
      failures++;
      $display("FAIL divu_by_zero: res=%h dz/ov=%b lat=%0d want ffffffff 10 0", r, {dz, ov}, lat);
    end
    issue_wait(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h0 || {dz, ov} !== 2'b01 || lat !== 0) begin
      failures++;
      $display("FAIL rem_overflow: res=%h dz/ov=%b lat=%0d want 00000000 01 0", r, {dz, ov}, lat);
    end
    issue_wait(3'b111, 32'h12345678, 32'd0, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h12345678 || {dz, ov} !== 2'b10) begin
      failures++;
      $display("FAIL remu_by_zero: res=%h dz/ov=%b want 12345678 10", r, {dz, ov});
    end
    issue_wait(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h80000000 || {dz, ov} !== 2'b01) begin
      failures++;
      $display("FAIL div_overflow: res=%h dz/ov=%b want 80000000 01", r, {dz, ov});
    end
  endtask

  task automatic test_hold();
    logic [31:0] r; int lat; logic dz, ov, sr; int bad;
    issue_wait(3'b101, 32'd100, 32'd7, r, lat, dz, ov, sr);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.result !== 32'd14) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_stable: %0d unstable cycles, want 0", bad); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1; bus.op = 3'b011; bus.operand1 = 32'h1; bus.operand2 = 32'h1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++; $display("FAIL hold_release: vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
    issue_wait(3'b011, 32'hFFFFFFFF, 32'h2, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'h1) begin failures++; $display("FAIL after_hold_op: got %h want 00000001", r); end
  endtask

  task automatic test_flush_rst();
    logic [31:0] r; int lat; logic dz, ov, sr; int seen;
    // Last consumed result was 0x00000001; flush must leave it untouched.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.operand1 = 32'd9; bus.operand2 = 32'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100 || bus.result !== 32'h1) begin
      failures++;
      $display("FAIL flush: rdy/busy/vld=%b result=%h want 100 00000001",
               {bus.in_ready, bus.busy, bus.out_valid}, bus.result);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_valid: out_valid seen %0d times want 0", seen); end
    bus.in_valid = 1'b1; bus.op = 3'b101; bus.operand1 = 32'd50; bus.operand2 = 32'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100 || bus.result !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_op: rdy/busy/vld=%b result=%h want 100 00000000",
               {bus.in_ready, bus.busy, bus.out_valid}, bus.result);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_no_valid: out_valid seen %0d times want 0", seen); end
    issue_wait(3'b100, 32'hFFFFFF9C, 32'd7, r, lat, dz, ov, sr); consume();
    checks++;
    if (r !== 32'hFFFFFFF2 || lat !== 33) begin
      failures++; $display("FAIL post_rst_div: res=%h lat=%0d want fffffff2 33", r, lat);
    end
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'b000;
    bus.operand1 = '0; bus.operand2 = '0; bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_hold();
    test_flush_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
